// File: rtl/spi_reg_receiver_pkg.sv
// Shared definitions for the SPI register receiver: frame geometry,
// register addresses, FSM state encoding and frame field helpers.
package spi_regs_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY      = 7'd4;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  function automatic logic frame_is_write(input logic [FRAME_BITS-1:0] f);
    return f[FRAME_BITS-1];
  endfunction

  function automatic logic [6:0] frame_addr(input logic [FRAME_BITS-1:0] f);
    return f[FRAME_BITS-2:FRAME_BITS-8];
  endfunction

  function automatic logic [7:0] frame_data(input logic [FRAME_BITS-1:0] f);
    return f[7:0];
  endfunction

endpackage

// File: rtl/spi_reg_receiver_if.sv
// Raw SPI pin bundle: the host drives it, the receiver samples it.
interface spi_reg_receiver_if;
  logic sclk_in;
  logic copi_in;
  logic ncs_in;

  modport master (output sclk_in, output copi_in, output ncs_in);
  modport slave  (input  sclk_in, input  copi_in, input  ncs_in);
endinterface

// File: rtl/spi_reg_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin followed by a history
// flop that yields single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchronizer chain plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_receiver.sv
// SPI mode-0 write-only target: commits 16-bit {W, addr[6:0], data[7:0]}
// frames into five control registers when nCS rises after exactly 16 bits.
module spi_reg_receiver
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic                clk,
  input  logic                rst,
  spi_reg_receiver_if.slave   spi,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle,
  output logic                wr_strobe,
  output logic                frame_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_rise, w_unused_sclk_level, w_unused_sclk_fall;
  logic w_copi_level, w_unused_copi_rise, w_unused_copi_fall;
  logic w_ncs_level, w_ncs_rise, w_ncs_fall;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_count;
  logic [7:0]            r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
  logic                  r_wr_strobe, r_frame_err;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_pin(spi.sclk_in),
    .o_level(w_unused_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_unused_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .i_pin(spi.copi_in),
    .o_level(w_copi_level), .o_rise(w_unused_copi_rise), .o_fall(w_unused_copi_fall)
  );

  // nCS idles high, so its synchronizer resets to 1 to avoid a false fall
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_pin(spi.ncs_in),
    .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  // Frame FSM, shifter, bit counter and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_en_out_lo <= 8'h00;
      r_en_out_hi <= 8'h00;
      r_en_pwm_lo <= 8'h00;
      r_en_pwm_hi <= 8'h00;
      r_duty      <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (w_ncs_level) r_state <= IDLE;
        end
        IDLE: begin
          if (w_ncs_fall) begin
            r_shift <= '0;
            r_count <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // nCS rising takes priority over a coincident sclk edge
          if (w_ncs_rise) begin
            r_state <= COMMIT;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_level};
            if (r_count != CNT_SAT) r_count <= r_count + CNT_W'(1);
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          if (r_count != CNT_FULL) begin
            r_frame_err <= 1'b1;
          end else if (frame_is_write(r_shift)) begin
            if (frame_addr(r_shift) > MAX_ADDR) begin
              r_frame_err <= 1'b1;
            end else begin
              r_wr_strobe <= 1'b1;
              case (frame_addr(r_shift))
                ADDR_EN_OUT_LO: r_en_out_lo <= frame_data(r_shift);
                ADDR_EN_OUT_HI: r_en_out_hi <= frame_data(r_shift);
                ADDR_EN_PWM_LO: r_en_pwm_lo <= frame_data(r_shift);
                ADDR_EN_PWM_HI: r_en_pwm_hi <= frame_data(r_shift);
                ADDR_DUTY:      r_duty      <= frame_data(r_shift);
                default:        r_wr_strobe <= 1'b0;
              endcase
            end
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign wr_strobe       = r_wr_strobe;
  assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_receiver.sv
// Scoreboard bench for spi_reg_receiver: the driver pushes the expected
// register image for each strobe/error event, a negedge monitor pops and compares.
module tb_spi_reg_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic wr_strobe, frame_err;

  spi_reg_receiver_if spi_if ();

  spi_reg_receiver dut (
    .clk(clk), .rst(rst), .spi(spi_if.slave),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [39:0] regs;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_regs[5];
  int         n_total = 0;
  int         n_pass  = 0;
  int         cyc     = 0;
  logic       ignore_err  = 1'b0;
  logic       strobe_seen = 1'b0;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_ERR  = 2;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic logic [39:0] model_image();
    return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  function automatic logic [39:0] dut_image();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] val, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi_if.copi_in = val[i];
      tick(4);
      spi_if.sclk_in = 1'b1;
      tick(4);
      spi_if.sclk_in = 1'b0;
    end
  endtask

  task automatic end_frame(input int kind, input int addr, input logic [7:0] data);
    tick(4);
    if (kind == K_WR) begin
      m_regs[addr] = data;
      exp_q.push_back('{is_err: 1'b0, regs: model_image()});
    end else if (kind == K_ERR) begin
      exp_q.push_back('{is_err: 1'b1, regs: model_image()});
    end
    spi_if.ncs_in = 1'b1;
    cyc = 0;
    tick(4);
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits, input int kind,
                            input int addr, input logic [7:0] data);
    spi_if.ncs_in = 1'b0;
    tick(4);
    shift_bits(val, nbits - 1, 0);
    end_frame(kind, addr, data);
  endtask

  task automatic check_regs(input string name);
    check(name, dut_image(), model_image());
  endtask

  // Monitor: every strobe or error pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (strobe_seen) check("strobe_width", wr_strobe, 1'b0);
      strobe_seen = wr_strobe;
      if (wr_strobe || (frame_err && !ignore_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {wr_strobe, frame_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {wr_strobe, frame_err}, e.is_err ? 2'b01 : 2'b10);
          check("event_regs", dut_image(), e.regs);
          check("event_latency", cyc, 4);
        end
      end
    end else begin
      strobe_seen = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    spi_if.ncs_in  = 1'b1;
    spi_if.sclk_in = 1'b0;
    spi_if.copi_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    check("reset_regs", dut_image(), 40'h0);
    check("reset_strobe", wr_strobe, 1'b0);
    check("reset_err", frame_err, 1'b0);

    // write duty (addr 4) <- 0x80
    send_frame(32'h8480, 16, K_WR, 4, 8'h80);
    check_regs("duty_write");
    // 0x8004 decodes as addr 0 <- 0x04
    send_frame(32'h8004, 16, K_WR, 0, 8'h04);
    check_regs("addr0_write");
    // back-to-back writes, nCS high 4 clk between frames
    send_frame(32'h80F0, 16, K_WR, 0, 8'hF0);
    send_frame(32'h82CC, 16, K_WR, 2, 8'hCC);
    check_regs("back_to_back");
    // read request: silently ignored
    send_frame(32'h0455, 16, K_NONE, 0, 8'h00);
    check_regs("read_ignored");
    // address 7 is beyond the register file
    send_frame(32'h87AA, 16, K_ERR, 0, 8'h00);
    check_regs("bad_addr");
    // short and long frames aimed at addr 1
    send_frame(32'h000040AD, 15, K_ERR, 0, 8'h00);
    check_regs("short_frame");
    send_frame(32'h0001815A, 17, K_ERR, 0, 8'h00);
    check_regs("long_frame");
    send_frame(32'h8312, 16, K_WR, 3, 8'h12);
    check_regs("hi_pwm_write");

    // reset mid-frame: the remainder must not produce a write
    spi_if.ncs_in = 1'b0;
    tick(4);
    shift_bits(32'h8133, 15, 8);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    tick(3);
    rst = 1'b0;
    ignore_err = 1'b1;
    shift_bits(32'h8133, 7, 0);
    end_frame(K_NONE, 0, 8'h00);
    tick(8);
    ignore_err = 1'b0;
    check_regs("reset_midframe");
    send_frame(32'h81FF, 16, K_WR, 1, 8'hFF);
    check_regs("after_reset_write");

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
